jk_bank_driver: RTL

- Controller that writes into an external bank of N JK flip-flops by generating their J/K excitation from requested target values.
- It is the write side of the JK interface: it accepts a target word over a valid/ready handshake and reads the bank state back via q_fb.
- It reaches the target either in one load step (excitation table) or by single-increment count steps (toggle excitation).
- It checks the result and reports done/error.

---
 rtl/jk_pkg.sv | 20 ++
 rtl/jk_bank.sv | 45 ++++
 rtl/jk_bank_driver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK bank write controller and its bank model.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } jk_state_t;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

  // Excitation for one bit moving from q to t; don't-cares resolve to 0 so
  // unchanged bits always see J=K=0.
  function automatic logic [1:0] jk_excite(input logic q, input logic t);
    return {~q & t, q & ~t};
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of N JK flip-flop cells; the load the driver writes into.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_bank #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] j,
  input  logic [N-1:0] k,
  output logic [N-1:0] q
);

  for (genvar g = 0; g < N; g++) begin : g_cell
    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j[g]),
      .k   (k[g]),
      .q   (q[g])
    );
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Write-side controller for an external JK bank: reaches a target word by a
// single load step or by repeated increments, then verifies it via q_fb.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_STEPS = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_target,
  input  logic         req_mode,
  input  logic [N-1:0] q_fb,
  output logic [N-1:0] j_o,
  output logic [N-1:0] k_o,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int SW = $clog2(MAX_STEPS) + 1;

  jk_state_t      state_q, state_d;
  logic [N-1:0]   target_q, target_d;
  logic           mode_q, mode_d;
  logic [SW-1:0]  steps_q, steps_d;
  logic [N-1:0]   j_d, k_d;
  logic           done_d, err_d;
  logic [N-1:0]   load_j, load_k;
  logic [N-1:0]   q_inc, toggle_m;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Bits that flip when the bank advances by one, including the wrap to zero.
  assign q_inc    = q_fb + N'(1);
  assign toggle_m = q_fb ^ q_inc;

  always_comb begin
    load_j = '0;
    load_k = '0;
    for (int i = 0; i < N; i++) begin
      {load_j[i], load_k[i]} = jk_excite(q_fb[i], req_target[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      mode_q   <= MODE_LOAD;
      steps_q  <= '0;
      j_o      <= '0;
      k_o      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      steps_q  <= steps_d;
      j_o      <= j_d;
      k_o      <= k_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

  // J/K are only non-zero for the single cycle spent in DRIVE.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    steps_d  = steps_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          mode_d   = req_mode;
          steps_d  = '0;
          if (req_mode == MODE_COUNT && q_fb == req_target) begin
            state_d = CHECK;
          end else begin
            state_d = DRIVE;
            if (req_mode == MODE_COUNT) begin
              j_d = toggle_m;
              k_d = toggle_m;
            end else begin
              j_d = load_j;
              k_d = load_k;
            end
          end
        end
      end
      DRIVE:  state_d = SETTLE;
      SETTLE: state_d = CHECK;
      CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (mode_q == MODE_LOAD || steps_q == SW'(MAX_STEPS)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          steps_d = steps_q + SW'(1);
          j_d     = toggle_m;
          k_d     = toggle_m;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
